udp_cmd_sequencer: RTL and testbench

//  Sits behind the UDP RX parser. Buffers the 32-bit UDP command words (one per rx_udp_dvld pulse) in a small FIFO.

---
 rtl/udp_cmd_pkg.sv | 30 +++
 rtl/udp_cmd_fifo.sv | 51 +++++
 rtl/udp_cmd_sequencer.sv | 179 +++++++++++++++++
 tb/tb_udp_cmd_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_cmd_pkg.sv
// Shared types for the UDP command sequencer: opcodes, command word layout, FSM states.
package udp_cmd_pkg;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_WRITE   = 2'b01,
    OP_READ    = 2'b10,
    OP_SEQSYNC = 2'b11
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [5:0]  seq;
    logic [7:0]  addr;
    logic [15:0] data;
  } cmd_t;

  localparam int unsigned S_IDLE_IDX  = 0;
  localparam int unsigned S_ISSUE_IDX = 1;
  localparam int unsigned S_RESP_IDX  = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'(1 << S_IDLE_IDX),
    S_ISSUE = 3'(1 << S_ISSUE_IDX),
    S_RESP  = 3'(1 << S_RESP_IDX)
  } state_t;

  localparam logic [1:0] RSP_TAG = 2'b10;

endpackage

// File: rtl/udp_cmd_fifo.sv
// First-word-fall-through command FIFO; pointers carry one extra wrap bit for full/empty.
module udp_cmd_fifo
  import udp_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t pop_data,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        push_ok, pop_ok;
  cmd_t        mem_q [DEPTH];

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/udp_cmd_sequencer.sv
// Buffers UDP command words, runs each as one register-bus transaction with ack timeout,
// returns read data over valid/ready. Optional sequence checking under UDP_CMD_SEQ_CHECK_EN.
module udp_cmd_sequencer
  import udp_cmd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_udp_dvld,
  input  logic [31:0] rx_udp_data,
  output logic        reg_req,
  output logic        reg_we,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  input  logic        reg_ack,
  input  logic [15:0] reg_rdata,
  output logic        rsp_vld,
  output logic [31:0] rsp_data,
  input  logic        rsp_rdy,
  output logic [7:0]  stat_ovf_cnt,
  output logic [7:0]  stat_tmo_cnt,
  output logic [7:0]  stat_seq_cnt
);

  localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

  state_t      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic        req_q, req_d;
  logic [15:0] wait_q, wait_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [7:0]  ovf_q, ovf_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        start;

  cmd_t fifo_out;
  logic fifo_full, fifo_empty, fifo_pop, fifo_push;

`ifdef UDP_CMD_SEQ_CHECK_EN
  logic [5:0] exp_seq_q, exp_seq_d;
  logic [7:0] seq_err_q, seq_err_d;
  assign stat_seq_cnt = seq_err_q;
`else
  assign stat_seq_cnt = '0;
`endif

  assign fifo_pop  = (state_q == S_IDLE) && !fifo_empty;
  assign fifo_push = rx_udp_dvld && (!fifo_full || fifo_pop);

  udp_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (cmd_t'(rx_udp_data)),
    .pop       (fifo_pop),
    .pop_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    req_d      = req_q;
    wait_d     = wait_q;
    rsp_vld_d  = rsp_vld_q;
    rsp_data_d = rsp_data_q;
    ovf_d      = ovf_q;
    tmo_d      = tmo_q;
    start      = 1'b0;
`ifdef UDP_CMD_SEQ_CHECK_EN
    exp_seq_d  = exp_seq_q;
    seq_err_d  = seq_err_q;
`endif
    if (rx_udp_dvld && !fifo_push && ovf_q != '1) ovf_d = ovf_q + 8'd1;

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          cmd_d = fifo_out;
          unique case (fifo_out.op)
            OP_WRITE, OP_READ: begin
`ifdef UDP_CMD_SEQ_CHECK_EN
              if (fifo_out.seq != exp_seq_q) begin
                if (seq_err_q != '1) seq_err_d = seq_err_q + 8'd1;
              end else begin
                exp_seq_d = fifo_out.seq + 6'd1;
                start     = 1'b1;
              end
`else
              start = 1'b1;
`endif
            end
            OP_SEQSYNC: begin
`ifdef UDP_CMD_SEQ_CHECK_EN
              exp_seq_d = fifo_out.seq + 6'd1;
`endif
            end
            OP_NOP: ;
          endcase
        end
        if (start) begin
          state_d = S_ISSUE;
          req_d   = 1'b1;
          wait_d  = '0;
        end
      end
      S_ISSUE: begin
        // An ack in the final allowed cycle wins over the timeout.
        if (reg_ack) begin
          req_d = 1'b0;
          if (cmd_q.op == OP_READ) begin
            rsp_vld_d  = 1'b1;
            rsp_data_d = {RSP_TAG, cmd_q.seq, cmd_q.addr, reg_rdata};
            state_d    = S_RESP;
          end else begin
            state_d = S_IDLE;
          end
        end else if (wait_q == TMO_LAST) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
          if (tmo_q != '1) tmo_d = tmo_q + 8'd1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_RESP: begin
        if (rsp_rdy) begin
          rsp_vld_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      req_q      <= 1'b0;
      wait_q     <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
      ovf_q      <= '0;
      tmo_q      <= '0;
`ifdef UDP_CMD_SEQ_CHECK_EN
      exp_seq_q  <= '0;
      seq_err_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      req_q      <= req_d;
      wait_q     <= wait_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
`ifdef UDP_CMD_SEQ_CHECK_EN
      exp_seq_q  <= exp_seq_d;
      seq_err_q  <= seq_err_d;
`endif
    end
  end

  assign reg_req      = req_q;
  assign reg_we       = (cmd_q.op == OP_WRITE);
  assign reg_addr     = cmd_q.addr;
  assign reg_wdata    = cmd_q.data;
  assign rsp_vld      = rsp_vld_q;
  assign rsp_data     = rsp_data_q;
  assign stat_ovf_cnt = ovf_q;
  assign stat_tmo_cnt = tmo_q;

endmodule

// File: tb/tb_udp_cmd_sequencer.sv
// Bench for udp_cmd_sequencer: queue-based reference model checked every cycle plus directed literal checks.
module tb_udp_cmd_sequencer;

  localparam int TB_DEPTH = 4;
  localparam int TB_TMO   = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_udp_dvld = 1'b0;
  logic [31:0] rx_udp_data = '0;
  logic        reg_req, reg_we;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_ack;
  logic [15:0] reg_rdata;
  logic        rsp_vld;
  logic [31:0] rsp_data;
  logic        rsp_rdy = 1'b0;
  logic [7:0]  stat_ovf_cnt, stat_tmo_cnt, stat_seq_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_delay = 3;
  logic [15:0] rdata_val = '0;
  int rise_cnt = 0;

  udp_cmd_sequencer #(.FIFO_DEPTH(TB_DEPTH), .ACK_TIMEOUT(TB_TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_udp_dvld  (rx_udp_dvld),
    .rx_udp_data  (rx_udp_data),
    .reg_req      (reg_req),
    .reg_we       (reg_we),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_ack      (reg_ack),
    .reg_rdata    (reg_rdata),
    .rsp_vld      (rsp_vld),
    .rsp_data     (rsp_data),
    .rsp_rdy      (rsp_rdy),
    .stat_ovf_cnt (stat_ovf_cnt),
    .stat_tmo_cnt (stat_tmo_cnt),
    .stat_seq_cnt (stat_seq_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] op, input logic [5:0] seq,
                                     input logic [7:0] a, input logic [15:0] d);
    return {op, seq, a, d};
  endfunction

  // Reference model: a queue for the FIFO, a mode (0 idle, 1 bus, 2 response) and plain counters.
  logic [31:0] mq[$];
  int          m_mode = 0;
  int          m_wait = 0;
  logic [31:0] m_cur  = '0;
  logic [31:0] m_rsp  = '0;
  int          m_ovf = 0, m_tmo = 0, m_seqc = 0;
  logic [5:0]  m_exp = '0;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mq.delete();
        m_mode = 0; m_wait = 0; m_ovf = 0; m_tmo = 0; m_seqc = 0; m_exp = '0;
      end else begin
        bit pop, acc;
        logic [31:0] w;
        pop = (m_mode == 0) && (mq.size() > 0);
        acc = rx_udp_dvld && ((mq.size() < TB_DEPTH) || pop);
        if (rx_udp_dvld && !acc && m_ovf < 255) m_ovf++;
        if (m_mode == 0) begin
          if (pop) begin
            w = mq.pop_front();
            if (w[31:30] == 2'b01 || w[31:30] == 2'b10) begin
`ifdef UDP_CMD_SEQ_CHECK_EN
              if (w[29:24] != m_exp) begin
                if (m_seqc < 255) m_seqc++;
              end else begin
                m_exp = w[29:24] + 6'd1;
                m_cur = w; m_mode = 1; m_wait = 0;
              end
`else
              m_cur = w; m_mode = 1; m_wait = 0;
`endif
            end
`ifdef UDP_CMD_SEQ_CHECK_EN
            if (w[31:30] == 2'b11) m_exp = w[29:24] + 6'd1;
`endif
          end
        end else if (m_mode == 1) begin
          if (reg_ack) begin
            if (m_cur[31:30] == 2'b10) begin
              m_rsp  = {2'b10, m_cur[29:16], reg_rdata};
              m_mode = 2;
            end else m_mode = 0;
          end else begin
            m_wait++;
            if (m_wait == TB_TMO) begin
              m_mode = 0;
              if (m_tmo < 255) m_tmo++;
            end
          end
        end else begin
          if (rsp_rdy) m_mode = 0;
        end
        if (acc) mq.push_back(rx_udp_data);
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      chk("reg_req", {31'b0, reg_req}, {31'b0, m_mode == 1});
      chk("rsp_vld", {31'b0, rsp_vld}, {31'b0, m_mode == 2});
      chk("ovf_cnt", {24'b0, stat_ovf_cnt}, 32'(m_ovf));
      chk("tmo_cnt", {24'b0, stat_tmo_cnt}, 32'(m_tmo));
      chk("seq_cnt", {24'b0, stat_seq_cnt}, 32'(m_seqc));
      if (m_mode == 1) begin
        chk("reg_we",    {31'b0, reg_we}, {31'b0, m_cur[31:30] == 2'b01});
        chk("reg_addr",  {24'b0, reg_addr}, {24'b0, m_cur[23:16]});
        chk("reg_wdata", {16'b0, reg_wdata}, {16'b0, m_cur[15:0]});
      end
      if (m_mode == 2) chk("rsp_data", rsp_data, m_rsp);
      if (reg_req && !prev_req) rise_cnt++;
      prev_req = reg_req;
    end
  end

  // Register slave: acks in the ack_delay-th cycle of a request; ack_delay <= 0 never acks.
  initial begin
    int cyc;
    cyc = 0;
    reg_ack = 1'b0;
    reg_rdata = '0;
    forever begin
      @(posedge clk); #1;
      reg_ack = 1'b0;
      if (reg_req) begin
        cyc++;
        if (ack_delay > 0 && cyc == ack_delay) begin
          reg_ack = 1'b1;
          reg_rdata = rdata_val;
        end
      end else cyc = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic pulse(input logic [31:0] w);
    rx_udp_dvld = 1'b1;
    rx_udp_data = w;
    @(posedge clk); #1;
    rx_udp_dvld = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (m_mode == 0 && mq.size() == 0 && !reg_req && !rsp_vld) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("wait_idle", {31'b0, ok}, 32'd1);
  endtask

  initial begin
    int cnt;
    bit got;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, reg_req}, 32'd0);
    chk("rst_rsp", rsp_data, 32'd0);
    chk("rst_addr", {24'b0, reg_addr}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: single write, 2-cycle latency, 3-cycle ack
    ack_delay = 3;
    pulse(32'h4012_BEEF);
    chk("t1_req_n1", {31'b0, reg_req}, 32'd0);
    @(posedge clk); #1;
    chk("t1_req_n2", {31'b0, reg_req}, 32'd1);
    chk("t1_we", {31'b0, reg_we}, 32'd1);
    chk("t1_addr", {24'b0, reg_addr}, 32'h12);
    chk("t1_wdata", {16'b0, reg_wdata}, 32'hBEEF);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (reg_req) cnt++;
      else break;
    end
    chk("t1_req_len", 32'(cnt), 32'd3);
    chk("t1_no_rsp", {31'b0, rsp_vld}, 32'd0);
    wait_idle(20);

    // 2: read with back-pressure on the response
    ack_delay = 2;
    rdata_val = 16'h1234;
    rsp_rdy = 1'b0;
    pulse(32'h8155_0000);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_vld) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("t2_rsp_seen", {31'b0, got}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_rsp_hold", {31'b0, rsp_vld}, 32'd1);
      chk("t2_rsp_data", rsp_data, 32'h8155_1234);
      @(posedge clk); #1;
    end
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    rsp_rdy = 1'b0;
    chk("t2_rsp_done", {31'b0, rsp_vld}, 32'd0);
    wait_idle(10);

    // 3: overflow burst with a silent slave
    ack_delay = -1;
    rise_cnt = 0;
    for (int i = 0; i < TB_DEPTH + 2; i++) begin
      rx_udp_dvld = 1'b1;
      rx_udp_data = mk(2'b01, 6'(2 + i), 8'(8'h30 + i), 16'(16'h1000 + i));
      @(posedge clk); #1;
    end
    rx_udp_dvld = 1'b0;
    wait_idle(400);
    chk("t3_ovf", {24'b0, stat_ovf_cnt}, 32'd1);
    chk("t3_tmo", {24'b0, stat_tmo_cnt}, 32'd5);
    chk("t3_attempts", 32'(rise_cnt), 32'd5);

    // 4: sequence checking
    ack_delay = 1;
    rise_cnt = 0;
    pulse(mk(2'b11, 6'd63, 8'h00, 16'h0000)); wait_idle(20);
    pulse(mk(2'b01, 6'd0, 8'h40, 16'h0A00));  wait_idle(20);
    pulse(mk(2'b01, 6'd1, 8'h41, 16'h0A01));  wait_idle(20);
    pulse(mk(2'b01, 6'd3, 8'h43, 16'h0A03));  wait_idle(20);
    pulse(mk(2'b11, 6'd3, 8'h00, 16'h0000));  wait_idle(20);
    pulse(mk(2'b01, 6'd4, 8'h44, 16'h0A04));  wait_idle(20);
`ifdef UDP_CMD_SEQ_CHECK_EN
    chk("t4_seq_cnt", {24'b0, stat_seq_cnt}, 32'd1);
    chk("t4_issued", 32'(rise_cnt), 32'd3);
`else
    chk("t4_seq_cnt", {24'b0, stat_seq_cnt}, 32'd0);
    chk("t4_issued", 32'(rise_cnt), 32'd4);
`endif

    // 5: reset mid-transaction with words queued
    ack_delay = -1;
    for (int i = 0; i < 3; i++) begin
      rx_udp_dvld = 1'b1;
      rx_udp_data = mk(2'b01, 6'(5 + i), 8'(8'h50 + i), 16'h5555);
      @(posedge clk); #1;
    end
    rx_udp_dvld = 1'b0;
    chk("t5_req_before", {31'b0, reg_req}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("t5_req_async", {31'b0, reg_req}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t5_tmo_clr", {24'b0, stat_tmo_cnt}, 32'd0);
    chk("t5_ovf_clr", {24'b0, stat_ovf_cnt}, 32'd0);
    chk("t5_seq_clr", {24'b0, stat_seq_cnt}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t5_fifo_empty", {31'b0, reg_req}, 32'd0);
    end
    ack_delay = 2;
    rdata_val = 16'hCAFE;
    rsp_rdy = 1'b1;
    pulse(mk(2'b10, 6'd0, 8'h77, 16'h0000));
    chk("t5_new_n1", {31'b0, reg_req}, 32'd0);
    @(posedge clk); #1;
    chk("t5_new_n2", {31'b0, reg_req}, 32'd1);
    chk("t5_new_addr", {24'b0, reg_addr}, 32'h77);
    wait_idle(20);
    rsp_rdy = 1'b0;

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
